i2c_txn_arbiter: RTL and testbench

// Shares one single-byte, sub-addressed I2C master engine between NREQ requesters.

---
 rtl/i2c_txn_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter
//   Shares one single-byte, sub-addressed I2C master engine between NREQ
//   requesters. Round-robin arbitration picks a requester. The block then
//   issues its command, waits for the engine, and re-issues after a NACK up to
//   MAX_RETRY times. It aborts when the engine stays silent for TIMEOUT cycles,
//   and finally returns a one-cycle response to the requester.
//
//   Every output is registered. A WAIT-state decision therefore shows up on the
//   following cycle. In particular, eng_abort is raised in the same cycle as
//   the RESP pulse. That pulse follows the WAIT cycle in which the timer
//   reached TIMEOUT-1 without eng_done.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req[NREQ]         level request per requester
//   req_rw[NREQ]      1 = read, 0 = write
//   req_dev[7*NREQ]   device address, requester i at [7i+6:7i]
//   req_sub[8*NREQ]   sub-address,    requester i at [8i+7:8i]
//   req_wdata[8*NREQ] write byte,     requester i at [8i+7:8i]
//   gnt[NREQ]         one-hot grant, held for the whole transaction
//   rsp_done[NREQ]    one-cycle completion pulse to the granted requester
//   rsp_err           with rsp_done: final NACK or timeout
//   rsp_rdata[8]      with rsp_done: read byte (0x00 for writes and errors)
//   eng_start         one-cycle start pulse to the engine
//   eng_abort         one-cycle abort pulse to the engine on timeout
//   eng_rw/dev/sub/wdata  latched command, stable from ISSUE through RESP
//   eng_done          one-cycle pulse: engine finished
//   eng_nack          with eng_done: slave did not acknowledge
//   eng_rdata[8]      with eng_done: read byte
// -----------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int NREQ      = 3,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 2,
  parameter int RETRY_GAP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [7*NREQ-1:0]   req_dev,
  input  logic [8*NREQ-1:0]   req_sub,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_done,
  output logic                rsp_err,
  output logic [7:0]          rsp_rdata,
  output logic                eng_start,
  output logic                eng_abort,
  output logic                eng_rw,
  output logic [6:0]          eng_dev,
  output logic [7:0]          eng_sub,
  output logic [7:0]          eng_wdata,
  input  logic                eng_done,
  input  logic                eng_nack,
  input  logic [7:0]          eng_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(RETRY_GAP + 1);

  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_END   = GW'(RETRY_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [CW-1:0]   retry_cnt;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;

  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  logic [2*NREQ-1:0] req_rot;
  logic [IW-1:0]     pick_off;
  logic [IW:0]       pick_sum;
  logic [IW-1:0]     winner;
  logic              any_req;

  always_comb begin
    // NOTE: every combinational signal gets a default first, so no path can
    // leave one unassigned and infer a latch.
    req_rot  = {req, req} >> rr_ptr;
    pick_off = '0;
    any_req  = |req;
    // Scan downward so that the lowest set bit is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_off = IW'(i);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= (IW+1)'(NREQ)) pick_sum = pick_sum - (IW+1)'(NREQ);
    winner = pick_sum[IW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      rsp_done  <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_rw    <= 1'b0;
      eng_dev   <= 7'h00;
      eng_sub   <= 8'h00;
      eng_wdata <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side here reads the value from before this clock edge.
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      rsp_done  <= '0;

      case (state)
        S_IDLE: begin
          if (any_req) begin
            win_idx   <= winner;
            gnt       <= NREQ'(1) << winner;
            eng_rw    <= req_rw[winner];
            eng_dev   <= req_dev[7*winner +: 7];
            eng_sub   <= req_sub[8*winner +: 8];
            eng_wdata <= req_wdata[8*winner +: 8];
            retry_cnt <= '0;
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (timer != {TW{1'b1}}) timer <= timer + 1'b1;
          // eng_done takes priority over a timeout that lands on the same cycle.
          if (eng_done) begin
            if (!eng_nack) begin
              rsp_done  <= gnt;
              rsp_err   <= 1'b0;
              rsp_rdata <= eng_rw ? eng_rdata : 8'h00;
              state     <= S_RESP;
            end else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else begin
              rsp_done  <= gnt;
              rsp_err   <= 1'b1;
              rsp_rdata <= 8'h00;
              state     <= S_RESP;
            end
          end else if (timer == TIMER_END) begin
            eng_abort <= 1'b1;
            rsp_done  <= gnt;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'h00;
            state     <= S_RESP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_END) begin
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_RESP: begin
          gnt    <= '0;
          rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_txn_arbiter
//   The bench acts as both the requesters and the I2C engine. For each
//   transaction, the engine's behaviour is decided in advance: a response
//   delay, NACK and read byte per attempt, or silence to force a timeout.
//   Because of that, the reference model can lay out the whole expected
//   timeline with plain arithmetic before the transaction runs. That timeline
//   covers the grant cycle, each start, the response cycle and the abort. A
//   single compare process checks every DUT output against that timeline on
//   every cycle. Directed cases add literal expectations, and a randomized
//   phase follows them.
// -----------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

  localparam int NREQ      = 3;
  localparam int TIMEOUT   = 4096;
  localparam int MAX_RETRY = 2;
  localparam int RETRY_GAP = 16;

  logic                clk;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_rw = '0;
  logic [7*NREQ-1:0]   req_dev = '0;
  logic [8*NREQ-1:0]   req_sub = '0;
  logic [8*NREQ-1:0]   req_wdata = '0;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_done;
  logic                rsp_err;
  logic [7:0]          rsp_rdata;
  logic                eng_start;
  logic                eng_abort;
  logic                eng_rw;
  logic [6:0]          eng_dev;
  logic [7:0]          eng_sub;
  logic [7:0]          eng_wdata;
  logic                eng_done = 1'b0;
  logic                eng_nack = 1'b0;
  logic [7:0]          eng_rdata = 8'h00;

  i2c_txn_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_rw(req_rw), .req_dev(req_dev), .req_sub(req_sub), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_rw(eng_rw), .eng_dev(eng_dev), .eng_sub(eng_sub), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: expected transaction timeline ----------
  int              m_first = -1;      // first cycle gnt / eng_* are valid
  int              m_resp  = -1;      // cycle of the rsp_done pulse
  int              m_starts[$];       // cycles carrying eng_start
  logic [NREQ-1:0] m_gnt   = '0;
  bit              m_abort = 1'b0;
  logic            m_err   = 1'b0;
  logic [7:0]      m_rdata = 8'h00;
  logic            m_rw    = 1'b0;
  logic [6:0]      m_dev   = '0;
  logic [7:0]      m_sub   = '0;
  logic [7:0]      m_wdata = '0;
  int              m_rr    = 0;
  bit              chk_en  = 1'b0;

  // Engine plan per attempt: delay after start (0 = never answer), NACK, byte.
  int         p_dly[3];
  bit         p_nack[3];
  logic [7:0] p_rd[3];
  bit         p_scramble = 1'b0;

  // Observations of the DUT for the literal checks.
  int              obs_starts[$];
  int              obs_abort[$];
  logic [NREQ-1:0] obs_done[$];
  logic            obs_err;
  logic [7:0]      obs_rdata;
  int              obs_done_cyc;
  logic [23:0]     obs_cmd;

  function automatic int arb_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- compare process ----------------
  bit              in_txn, at_resp, is_start;
  logic [NREQ-1:0] exp_gnt, exp_done;

  always @(negedge clk) begin
    if (chk_en) begin
      in_txn   = (cyc >= m_first) && (cyc <= m_resp);
      at_resp  = (cyc == m_resp);
      is_start = 1'b0;
      foreach (m_starts[k]) if (m_starts[k] == cyc) is_start = 1'b1;
      exp_gnt  = in_txn  ? m_gnt : '0;
      exp_done = at_resp ? m_gnt : '0;
      check("gnt",       32'(gnt),       32'(exp_gnt));
      check("eng_start", 32'(eng_start), 32'(is_start));
      check("eng_abort", 32'(eng_abort), 32'(m_abort && at_resp));
      check("rsp_done",  32'(rsp_done),  32'(exp_done));
      if (at_resp) begin
        check("rsp_err",   32'(rsp_err),   32'(m_err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      end
      if (in_txn) begin
        check("eng_rw",    32'(eng_rw),    32'(m_rw));
        check("eng_dev",   32'(eng_dev),   32'(m_dev));
        check("eng_sub",   32'(eng_sub),   32'(m_sub));
        check("eng_wdata", 32'(eng_wdata), 32'(m_wdata));
      end
      if (eng_start) begin
        obs_starts.push_back(cyc);
        obs_cmd = {eng_rw, eng_dev, eng_sub, eng_wdata};
      end
      if (eng_abort) obs_abort.push_back(cyc);
      if (|rsp_done) begin
        obs_done.push_back(rsp_done);
        obs_err      = rsp_err;
        obs_rdata    = rsp_rdata;
        obs_done_cyc = cyc;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_obs();
    obs_starts.delete();
    obs_abort.delete();
    obs_done.delete();
    obs_err      = 1'bx;
    obs_rdata    = 8'hxx;
    obs_done_cyc = -1;
    obs_cmd      = 'x;
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [6:0] dev,
                         input logic [7:0] sub, input logic [7:0] wd);
    req_rw[i]           = rw;
    req_dev[7*i +: 7]   = dev;
    req_sub[8*i +: 8]   = sub;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic set_plan(input int d0, input bit n0, input logic [7:0] r0,
                          input int d1, input bit n1, input logic [7:0] r1,
                          input int d2, input bit n2, input logic [7:0] r2);
    p_dly[0] = d0; p_nack[0] = n0; p_rd[0] = r0;
    p_dly[1] = d1; p_nack[1] = n1; p_rd[1] = r1;
    p_dly[2] = d2; p_nack[2] = n2; p_rd[2] = r2;
  endtask

  // Async reset pulse; clears the model. Entered and left at posedge+1.
  task automatic apply_reset();
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    req      = '0;
    eng_done = 1'b0;
    m_first  = -1;
    m_resp   = -1;
    m_starts.delete();
    m_abort  = 1'b0;
    m_rr     = 0;
    #1;
    check("rst_gnt",       32'(gnt),       32'(0));
    check("rst_rsp_done",  32'(rsp_done),  32'(0));
    check("rst_eng_start", 32'(eng_start), 32'(0));
    check("rst_eng_abort", 32'(eng_abort), 32'(0));
    check("rst_rsp_err",   32'(rsp_err),   32'(0));
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    check("rst_eng_cmd",   32'({eng_rw, eng_dev, eng_sub, eng_wdata}), 32'(0));
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold_rsp_done", 32'(rsp_done), 32'(0));
      check("rst_hold_gnt",      32'(gnt),      32'(0));
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  // Called at posedge+1 of a cycle in which the DUT is idle and req/command
  // inputs are already set. Builds the expected timeline, then plays the
  // engine. Returns at posedge+1 of the next idle cycle. If stop_after > 0,
  // it returns early, stop_after cycles after entry.
  task automatic run_txn(input int stop_after);
    int c, w, s, k, d;
    int wait_lo[$], wait_hi[$], done_at[$];
    bit nk_at[$];
    logic [7:0] rd_at[$];
    bit inw, dn, dnk;
    logic [7:0] drd;
    c = cyc;
    w = arb_pick(req, m_rr);
    if (w < 0) begin
      @(posedge clk); #1;
      return;
    end
    m_gnt    = '0;
    m_gnt[w] = 1'b1;
    m_rw     = req_rw[w];
    m_dev    = req_dev[7*w +: 7];
    m_sub    = req_sub[8*w +: 8];
    m_wdata  = req_wdata[8*w +: 8];
    m_starts.delete();
    s = c + 1;
    k = 0;
    forever begin
      m_starts.push_back(s);
      if (p_dly[k] == 0) begin
        // Silent engine: the timer reaches TIMEOUT-1 on cycle s+TIMEOUT.
        wait_lo.push_back(s + 1); wait_hi.push_back(s + TIMEOUT);
        done_at.push_back(-1); nk_at.push_back(1'b0); rd_at.push_back(8'h00);
        m_resp = s + TIMEOUT + 1; m_abort = 1'b1; m_err = 1'b1; m_rdata = 8'h00;
        break;
      end
      d = s + p_dly[k];
      wait_lo.push_back(s + 1); wait_hi.push_back(d);
      done_at.push_back(d); nk_at.push_back(p_nack[k]); rd_at.push_back(p_rd[k]);
      if (!p_nack[k]) begin
        m_resp = d + 1; m_abort = 1'b0; m_err = 1'b0;
        m_rdata = m_rw ? p_rd[k] : 8'h00;
        break;
      end
      if (k == MAX_RETRY) begin
        m_resp = d + 1; m_abort = 1'b0; m_err = 1'b1; m_rdata = 8'h00;
        break;
      end
      k++;
      s = d + RETRY_GAP + 1;
    end
    m_first = c + 1;
    m_rr    = (w + 1) % NREQ;

    while (cyc < m_resp) begin
      if (stop_after > 0 && cyc >= c + stop_after) return;
      @(posedge clk); #1;
      inw = 1'b0; dn = 1'b0; dnk = 1'b0; drd = 8'h00;
      foreach (wait_lo[a]) begin
        if (cyc >= wait_lo[a] && cyc <= wait_hi[a]) begin
          inw = 1'b1;
          if (cyc == done_at[a]) begin
            dn = 1'b1; dnk = nk_at[a]; drd = rd_at[a];
          end
        end
      end
      if (inw) begin
        eng_done  = dn;
        eng_nack  = dn ? dnk : 1'($urandom);
        eng_rdata = dn ? drd : 8'($urandom);
      end else begin
        // Outside WAIT the engine handshake must be ignored.
        eng_done  = ($urandom_range(0, 4) == 0);
        eng_nack  = 1'($urandom);
        eng_rdata = 8'($urandom);
      end
      if (p_scramble) begin
        req       = NREQ'($urandom);
        req_rw    = NREQ'($urandom);
        req_dev   = (7*NREQ)'($urandom);
        req_sub   = (8*NREQ)'($urandom);
        req_wdata = (8*NREQ)'($urandom);
      end
    end
    @(posedge clk); #1;
    eng_done = 1'b0;
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    #2;
    apply_reset();

    // Contention: all three held, rr_ptr = 0 after reset.
    clear_obs();
    p_scramble = 1'b0;
    set_cmd(0, 1'b0, 7'h11, 8'h01, 8'h10);
    set_cmd(1, 1'b1, 7'h22, 8'h02, 8'h20);
    set_cmd(2, 1'b0, 7'h33, 8'h03, 8'h30);
    set_plan(3, 1'b0, 8'h5A, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    req = 3'b111;
    repeat (4) run_txn(0);
    req = '0;
    check("rr_count",  32'(obs_done.size()), 32'(4));
    check("rr_grant0", 32'((obs_done.size() > 0) ? obs_done[0] : 3'b111), 32'(3'b001));
    check("rr_grant1", 32'((obs_done.size() > 1) ? obs_done[1] : 3'b111), 32'(3'b010));
    check("rr_grant2", 32'((obs_done.size() > 2) ? obs_done[2] : 3'b111), 32'(3'b100));
    check("rr_grant3", 32'((obs_done.size() > 3) ? obs_done[3] : 3'b111), 32'(3'b001));
    repeat (2) begin @(posedge clk); #1; end

    // Single write from requester 1; engine answers 10 cycles after start.
    clear_obs();
    set_cmd(1, 1'b0, 7'h50, 8'h20, 8'hA5);
    set_plan(10, 1'b0, 8'hEE, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    req = 3'b010;
    run_txn(0);
    req = '0;
    check("wr_starts",  32'(obs_starts.size()), 32'(1));
    check("wr_cmd",     32'(obs_cmd),           32'(24'h5020A5));
    check("wr_done",    32'((obs_done.size() > 0) ? obs_done[0] : 3'b111), 32'(3'b010));
    check("wr_err",     32'(obs_err),           32'(0));
    check("wr_rdata",   32'(obs_rdata),         32'(8'h00));
    check("wr_latency", 32'(obs_done_cyc - ((obs_starts.size() > 0) ? obs_starts[0] : 0)), 32'(11));

    // Read: NACK, NACK, then ACK with 0x3C.
    clear_obs();
    set_cmd(0, 1'b1, 7'h48, 8'h0F, 8'h00);
    set_plan(10, 1'b1, 8'h99, 10, 1'b1, 8'h98, 10, 1'b0, 8'h3C);
    req = 3'b001;
    run_txn(0);
    req = '0;
    check("rty_starts", 32'(obs_starts.size()), 32'(3));
    check("rty_gap1",   32'((obs_starts.size() > 1) ? obs_starts[1] - obs_starts[0] : 0), 32'(27));
    check("rty_gap2",   32'((obs_starts.size() > 2) ? obs_starts[2] - obs_starts[1] : 0), 32'(27));
    check("rty_err",    32'(obs_err),   32'(0));
    check("rty_rdata",  32'(obs_rdata), 32'(8'h3C));

    // NACK on every attempt.
    clear_obs();
    set_cmd(2, 1'b1, 7'h3A, 8'h44, 8'h00);
    set_plan(5, 1'b1, 8'hFF, 7, 1'b1, 8'hFF, 2, 1'b1, 8'hFF);
    req = 3'b100;
    run_txn(0);
    req = '0;
    check("nak_starts", 32'(obs_starts.size()), 32'(3));
    check("nak_err",    32'(obs_err),   32'(1));
    check("nak_rdata",  32'(obs_rdata), 32'(8'h00));

    // Silent engine: abort after TIMEOUT cycles in WAIT.
    clear_obs();
    set_cmd(1, 1'b1, 7'h0C, 8'h55, 8'h00);
    set_plan(0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    req = 3'b010;
    run_txn(0);
    req = '0;
    check("to_aborts",   32'(obs_abort.size()), 32'(1));
    check("to_abort_at", 32'((obs_abort.size() > 0) ? obs_abort[0] - obs_starts[0] : 0), 32'(TIMEOUT + 1));
    check("to_resp_at",  32'(obs_done_cyc - ((obs_starts.size() > 0) ? obs_starts[0] : 0)), 32'(TIMEOUT + 1));
    check("to_err",      32'(obs_err), 32'(1));

    // eng_done on the timeout cycle itself wins over the abort.
    clear_obs();
    set_cmd(0, 1'b1, 7'h0D, 8'h56, 8'h00);
    set_plan(TIMEOUT, 1'b0, 8'h77, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    req = 3'b001;
    run_txn(0);
    req = '0;
    check("tw_aborts", 32'(obs_abort.size()), 32'(0));
    check("tw_err",    32'(obs_err),   32'(0));
    check("tw_rdata",  32'(obs_rdata), 32'(8'h77));

    // Reset in the middle of WAIT: the transaction vanishes silently.
    clear_obs();
    set_cmd(1, 1'b0, 7'h21, 8'h31, 8'h41);
    set_plan(0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    req = 3'b010;
    run_txn(20);
    apply_reset();
    check("rst_no_done", 32'(obs_done.size()), 32'(0));
    clear_obs();
    set_cmd(2, 1'b0, 7'h61, 8'h71, 8'h81);
    set_plan(4, 1'b0, 8'h00, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
    req = 3'b100;
    run_txn(0);
    req = '0;
    check("rst_first_grant", 32'((obs_done.size() > 0) ? obs_done[0] : 3'b111), 32'(3'b100));

    // Randomized traffic, inputs scrambled while each transaction runs.
    p_scramble = 1'b1;
    for (int n = 0; n < 60; n++) begin
      req       = NREQ'($urandom);
      req_rw    = NREQ'($urandom);
      req_dev   = (7*NREQ)'($urandom);
      req_sub   = (8*NREQ)'($urandom);
      req_wdata = (8*NREQ)'($urandom);
      for (int k = 0; k < 3; k++) begin
        p_dly[k]  = $urandom_range(1, 25);
        p_nack[k] = ($urandom_range(0, 2) == 0);
        p_rd[k]   = 8'($urandom);
      end
      run_txn(0);
    end
    req = '0;
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 60000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
